// File: rtl/tt_um_uwasic_onboarding_kelly_duong.sv
// UWASIC onboarding top: write-only SPI (mode 0) register file driving 16 PWM/static outputs.
// Optional macro PWM_SYNC_UPDATE_EN: duty writes are shadowed and applied at the PWM period boundary.
module tt_um_uwasic_onboarding_kelly_duong #(
  parameter int CLK_DIV  = 13,
  parameter int NUM_REGS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DATA_W = 8;
  localparam int OUT_W  = 16;
  localparam int CNT_W  = 5;
  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] FRAME_BITS = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT    = 5'd17;
  localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(CLK_DIV - 1);
  localparam logic [6:0]       ADDR_MAX   = 7'(NUM_REGS - 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // Counter stops one past a full frame so over-long frames can never look valid.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_SAT) ? CNT_SAT : v + 1'b1;
  endfunction

  function automatic logic pwm_level(input logic [DATA_W-1:0] cnt,
                                     input logic [DATA_W-1:0] dty);
    return (dty == 8'hFF) ? 1'b1 : (cnt < dty);
  endfunction

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

  // Stage p0/p1: two-flop synchronizers; p2 holds the previous value for edge detection
  logic sclk_p0, sclk_p1, sclk_p2;
  logic copi_p0, copi_p1;
  logic ncs_p0, ncs_p1, ncs_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      copi_p0 <= 1'b0;
      copi_p1 <= 1'b0;
      ncs_p0  <= 1'b1;
      ncs_p1  <= 1'b1;
      ncs_p2  <= 1'b1;
    end else begin
      sclk_p0 <= ui_in[0];
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      copi_p0 <= ui_in[1];
      copi_p1 <= copi_p0;
      ncs_p0  <= ui_in[2];
      ncs_p1  <= ncs_p0;
      ncs_p2  <= ncs_p1;
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise;
  assign sclk_rise = sclk_p1 & ~sclk_p2;
  assign ncs_fall  = ~ncs_p1 & ncs_p2;
  assign ncs_rise  = ncs_p1 & ~ncs_p2;

  typedef enum logic [1:0] {
    SPI_IDLE   = 2'd0,
    SPI_SHIFT  = 2'd1,
    SPI_COMMIT = 2'd2
  } spi_state_t;

  spi_state_t         state, state_nxt;
  logic               frame_clr, frame_shift, frame_ok, wr_en;
  logic [CNT_W-1:0]   bit_cnt;
  logic [15:0]        shift_reg;
  logic [6:0]         wr_addr;
  logic [DATA_W-1:0]  wr_data;

  assign wr_addr  = shift_reg[14:8];
  assign wr_data  = shift_reg[7:0];
  assign frame_ok = (bit_cnt == FRAME_BITS) && shift_reg[15] && (wr_addr <= ADDR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SPI_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_clr   = 1'b0;
    frame_shift = 1'b0;
    wr_en       = 1'b0;
    case (state)
      SPI_IDLE: begin
        if (ncs_fall) begin
          frame_clr = 1'b1;
          state_nxt = SPI_SHIFT;
        end
      end
      SPI_SHIFT: begin
        if (ncs_rise)       state_nxt   = frame_ok ? SPI_COMMIT : SPI_IDLE;
        else if (sclk_rise) frame_shift = 1'b1;
      end
      SPI_COMMIT: begin
        wr_en = 1'b1;
        // A back-to-back frame may already be starting; do not lose its nCS fall.
        if (ncs_fall) begin
          frame_clr = 1'b1;
          state_nxt = SPI_SHIFT;
        end else begin
          state_nxt = SPI_IDLE;
        end
      end
      default: state_nxt = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (frame_clr) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (frame_shift) begin
      bit_cnt   <= sat_inc(bit_cnt);
      shift_reg <= {shift_reg[14:0], copi_p1};
    end
  end

  logic [OUT_W-1:0]  en_out, en_pwm;
  logic [DATA_W-1:0] duty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= '0;
      en_pwm <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: en_out[7:0]  <= wr_data;
        ADDR_EN_OUT_HI: en_out[15:8] <= wr_data;
        ADDR_EN_PWM_LO: en_pwm[7:0]  <= wr_data;
        ADDR_EN_PWM_HI: en_pwm[15:8] <= wr_data;
        default: ;
      endcase
    end
  end

  logic [PRE_W-1:0]  prescale;
  logic [DATA_W-1:0] pwm_counter;
  logic              pre_wrap, pwm_wrap;

  assign pre_wrap = (prescale == PRE_MAX);
  assign pwm_wrap = pre_wrap && (pwm_counter == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale    <= '0;
      pwm_counter <= '0;
    end else begin
      prescale <= pre_wrap ? '0 : prescale + 1'b1;
      if (pre_wrap) pwm_counter <= pwm_counter + 1'b1;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [DATA_W-1:0] duty_shadow;
  logic              duty_wr;
  assign duty_wr = wr_en && (wr_addr == ADDR_DUTY);

  // Active duty only changes at the 255->0 wrap; a write landing on that cycle goes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty        <= '0;
    end else begin
      if (duty_wr)  duty_shadow <= wr_data;
      if (pwm_wrap) duty        <= duty_wr ? wr_data : duty_shadow;
    end
  end
`else
  logic pwm_wrap_unused;
  assign pwm_wrap_unused = pwm_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                duty <= '0;
    else if (wr_en && (wr_addr == ADDR_DUTY))  duty <= wr_data;
  end
`endif

  logic             pwm_signal;
  logic [OUT_W-1:0] out_nxt, out_p0;

  assign pwm_signal = pwm_level(pwm_counter, duty);
  assign out_nxt    = en_out & (~en_pwm | {OUT_W{pwm_signal}});

  // Stage p0: registered outputs, all PWM channels share one phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_p0 <= '0;
    else        out_p0 <= out_nxt;
  end

  assign uo_out  = out_p0[7:0];
  assign uio_out = out_p0[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_kelly_duong.sv
// Directed + randomized bench for tt_um_uwasic_onboarding_kelly_duong with a register-map reference model.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_kelly_duong;

  localparam int PERIOD = 256 * 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  assign ui_in  = {5'b0, ncs, copi, sclk};
  assign uio_in = 8'h00;

  tt_um_uwasic_onboarding_kelly_duong dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl [0:4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Register-map rule: only complete 16-bit writes to 0..4 land.
  task automatic model_frame(input logic [31:0] w, input int n);
    if (n == 16 && w[15] && w[14:8] < 7'd5) mdl[int'(w[14:8])] = w[7:0];
  endtask

  task automatic model_expect(output logic [15:0] exp, output logic [15:0] mask);
    logic [15:0] eo, ep;
    eo = {mdl[1], mdl[0]};
    ep = {mdl[3], mdl[2]};
    exp = '0;
    mask = '1;
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])               exp[i] = 1'b0;
      else if (!ep[i])          exp[i] = 1'b1;
      else if (mdl[4] == 8'h00) exp[i] = 1'b0;
      else if (mdl[4] == 8'hFF) exp[i] = 1'b1;
      else                      mask[i] = 1'b0;
    end
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] w, input int n);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) spi_bit(w[i]);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    model_frame(w, n);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame({16'h0, 1'b1, a, d}, 16);
  endtask

  task automatic measure_pwm(output int hi, output int per, output bit ok);
    int n;
    ok = 1'b1; hi = 0; per = 0;
    n = 0;
    while (uo_out[0] !== 1'b0 && n < 8000) begin @(negedge clk); n++; end
    if (n >= 8000) ok = 1'b0;
    n = 0;
    while (uo_out[0] !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
    if (n >= 8000) ok = 1'b0;
    while (ok && uo_out[0] === 1'b1 && hi < 8000) begin @(negedge clk); hi++; end
    per = hi;
    while (ok && uo_out[0] === 1'b0 && per < 16000) begin @(negedge clk); per++; end
    if (hi >= 8000 || per >= 16000) ok = 1'b0;
  endtask

  initial begin
    logic [15:0] exp, mask, snap;
    logic [31:0] w;
    logic [6:0]  a;
    logic [7:0]  d;
    int kind, n, bad, hi, per;
    bit ok;

    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

    // Reset
    repeat (5) @(negedge clk);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hFF);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_out", {uio_out, uo_out}, 16'h0000);

    // Static enables
    wr(7'h00, 8'hF0);
    wr(7'h01, 8'hCC);
    check("static_uo", uo_out, 8'hF0);
    check("static_uio", uio_out, 8'hCC);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if ({uio_out, uo_out} !== 16'hCCF0) bad++;
    end
    check("static_stable", bad, 0);

    // Randomized frames against the model
    for (int t = 0; t < 24; t++) begin
      kind = $urandom_range(0, 9);
      d = 8'($urandom);
      a = 7'($urandom_range(0, 4));
      n = 16;
      if (a == 7'd4) begin
        case ($urandom_range(0, 2))
          0: d = 8'h00;
          1: d = 8'hFF;
          default: ;
        endcase
      end
      if (kind <= 5)      w = {16'h0, 1'b1, a, d};
      else if (kind == 6) w = {16'h0, 1'b0, a, d};
      else if (kind == 7) w = {16'h0, 1'b1, 7'($urandom_range(5, 127)), d};
      else if (kind == 8) begin w = {17'h0, 1'b1, a, d[7:1]}; n = 15; end
      else                begin w = {15'h0, 1'b1, a, d, 1'($urandom)}; n = 17; end
      spi_frame(w, n);
      model_expect(exp, mask);
      check($sformatf("rand%0d_k%0d", t, kind), {uio_out, uo_out} & mask, exp & mask);
    end

    // PWM duty 50%
    wr(7'h00, 8'h01); wr(7'h01, 8'h00); wr(7'h02, 8'h01); wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    measure_pwm(hi, per, ok);
    check("pwm80_edges", ok, 1);
    check_range("pwm80_period", per, PERIOD - 1, PERIOD + 1);
    check_range("pwm80_high", hi, 1664 - 13, 1664 + 13);
    check("pwm80_others", {uio_out, uo_out[7:1]}, 15'h0);

    // PWM random duty
    d = 8'($urandom_range(1, 254));
    wr(7'h04, d);
    measure_pwm(hi, per, ok);
    check("pwmrnd_edges", ok, 1);
    check_range("pwmrnd_period", per, PERIOD - 1, PERIOD + 1);
    check_range("pwmrnd_high", hi, int'(d) * 13 - 13, int'(d) * 13 + 13);

    // Duty extremes
    wr(7'h04, 8'h00);
    bad = 0;
    repeat (2 * PERIOD) begin @(negedge clk); if (uo_out !== 8'h00) bad++; end
    check("duty00_low", bad, 0);
    wr(7'h04, 8'hFF);
    bad = 0;
    repeat (2 * PERIOD) begin @(negedge clk); if (uo_out !== 8'h01) bad++; end
    check("dutyFF_high", bad, 0);

    // Ignored frames
    wr(7'h00, 8'hA5); wr(7'h01, 8'h5A); wr(7'h02, 8'h00); wr(7'h03, 8'h00);
    snap = {uio_out, uo_out};
    check("ign_base", snap, 16'h5AA5);
    spi_frame({16'h0, 1'b0, 7'h00, 8'hFF}, 16);
    check("ign_read", {uio_out, uo_out}, 16'h5AA5);
    spi_frame({16'h0, 1'b1, 7'h05, 8'hFF}, 16);
    check("ign_addr05", {uio_out, uo_out}, 16'h5AA5);
    spi_frame({16'h0, 1'b1, 7'h7F, 8'hFF}, 16);
    check("ign_addr7F", {uio_out, uo_out}, 16'h5AA5);
    spi_frame({17'h0, 1'b1, 7'h00, 7'h7F}, 15);
    check("ign_15bit", {uio_out, uo_out}, 16'h5AA5);
    spi_frame({15'h0, 1'b1, 7'h00, 8'hFF, 1'b1}, 17);
    check("ign_17bit", {uio_out, uo_out}, 16'h5AA5);

    // Reset mid-frame
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    spi_bit(1'b1);
    for (int i = 0; i < 7; i++) spi_bit(1'b0);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_during", {uio_out, uo_out}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
    check("midrst_after", {uio_out, uo_out}, 16'h0000);
    wr(7'h00, 8'h01);
    check("midrst_fresh", uo_out, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tt_um_uwasic_onboarding_kelly_duong.md
Name: tt_um_uwasic_onboarding_kelly_duong

Overview:
- Tiny Tapeout user-project top for the UWASIC onboarding design.
- An SPI peripheral (write-only, mode 0) loads a 5-entry register file.
- A PWM peripheral drives 16 outputs from that register file: uo_out[7:0] and uio_out[7:0].
- Each output is individually enabled, and individually switched between static-high and PWM.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step (10 MHz / 13 / 256 ≈ 3.0 kHz PWM frequency).
- NUM_REGS, 5, number of implemented register addresses (0x00–0x04).

Ports:
- clk  input  1  system clock, 10 MHz nominal.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design selected; ignored, logic runs regardless.
- ui_in  input  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused.
- uo_out  output  8  PWM/static outputs 7..0.
- uio_in  input  8  unused.
- uio_out  output  8  PWM/static outputs 15..8.
- uio_oe  output  8  constant 8'hFF (all bidirectionals are outputs).

Behaviour:
- Reset (rst_n=0, asynchronous): all registers 0x00, all counters 0, SPI state idle, uo_out=0, uio_out=0; uio_oe stays 8'hFF.
- Register map:
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty[7:0]
- SPI input synchronization: SCLK, COPI and nCS each pass through a 2-flop synchronizer in clk. Edges are detected on the synchronized SCLK. This requires SCLK ≤ clk/4.
- SPI frame:
  - nCS falling clears the bit counter and shift register.
  - While nCS is low, COPI is sampled on each synchronized SCLK rising edge, MSB first.
  - Exactly 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- SPI commit:
  - The frame commits on nCS rising, only if exactly 16 bits were received, R/W=1, and address ≤ 0x04.
  - Commit happens within 2 clk after synchronized nCS rises.
- SPI frames that are ignored (no register changes):
  - reads (R/W=0);
  - addresses 0x05–0x7F;
  - frames with ≠16 bits;
  - bits beyond 16 (counter saturates and the frame is dropped).
- SPI has no read-back output; CIPO is not implemented.
- Reset mid-frame aborts the frame; no partial write.
- PWM timebase:
  - A prescaler counts 0..CLK_DIV-1.
  - On wrap, an 8-bit pwm_counter increments 0..255 and wraps to 0.
- PWM signal:
  - pwm_signal = 1 if duty==0xFF.
  - Otherwise pwm_signal = (pwm_counter < duty).
  - Hence duty 0x00 is constant low and 0x80 gives 50%.
- Per-output i (0..15), registered one clk after the inputs settle:
  - out[i] = en_out[i] ? (en_pwm[i] ? pwm_signal : 1) : 0.
  - All PWM-enabled outputs are in phase.
- Output mapping: uo_out = out[7:0]; uio_out = out[15:8].
- Register writes take effect on the next clk after commit (see Optional Feature for duty).

Optional Feature:
- Macro PWM_SYNC_UPDATE_EN.
- Defined: a written duty value is held in a shadow register. It is transferred to the active duty only when pwm_counter wraps 255→0, so no glitched or truncated periods occur. en_out and en_pwm still update immediately.
- Undefined: duty writes update the active duty immediately, mid-period.

Test Plan:
- Reset: assert rst_n=0 for 5 clk → uo_out=0x00, uio_out=0x00, uio_oe=0xFF. Release → outputs stay 0.
- Static enable: write 0x00←0xF0, 0x01←0xCC → uo_out=0xF0, uio_out=0xCC, stable over 1000 clk.
- PWM duty: write 0x00←0x01, 0x02←0x01, 0x04←0x80 → uo_out[0] period ≈ 3328 clk (256×13), high ≈ 1664 clk (±13). Other uo_out bits are 0.
- Duty extremes: duty 0x00 → uo_out[0] constant 0; duty 0xFF → constant 1 across ≥2 periods.
- Ignored frames: each of the following leaves all registers unchanged and outputs identical:
  - read frame 0x00,0xFF;
  - write to address 0x05 or 0x7F;
  - 15-bit frame;
  - 17-bit frame.
- Reset mid-operation: pull rst_n low after 8 SCLK bits of a write to 0x00 → registers stay 0. After release, a fresh write 0x00←0x01 gives uo_out[0]=1.
